// File: rtl/csa_accum_pkg.sv
// csa_pkg: shared FSM state type and lane-slicing helper for the carry-save accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACC     = 2'd1,
        RESOLVE = 2'd2,
        HOLD    = 2'd3
    } csa_state_e;

    // LSB position of a lane inside a packed multi-lane operand bus.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/csa_accum_row.sv
// csa_row: one row of W-bit 3:2 compressors; carry word pre-shifted and truncated to W bits.
// Latency: combinational.
// Backpressure: none. With CSA_ACCUM_OVF_EN, cout_msb reports the majority bit dropped off the top.
module csa_row #(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
`ifdef CSA_ACCUM_OVF_EN
    output logic         cout_msb,
`endif
    output logic [W-1:0] s,
    output logic [W-1:0] cy
);

    assign s  = a ^ b ^ c;
    // Majority shifted one place up; the bit that would land at position W is dropped.
    assign cy = ((a & b) | (a & c) | (b & c)) << 1;

`ifdef CSA_ACCUM_OVF_EN
    assign cout_msb = (a[W-1] & b[W-1]) | (a[W-1] & c[W-1]) | (b[W-1] & c[W-1]);
`endif

endmodule

// File: rtl/csa_accum.sv
// csa_accum: multi-beat accumulator folding LANES operands per beat into a sum/carry pair; one carry-propagate add per packet.
// Latency: last beat accepted at edge t, out_valid high after edge t+1; two bubble cycles per packet.
// Backpressure: registered in_ready, low in RESOLVE/HOLD; result held until out_ready. CSA_ACCUM_OVF_EN adds out_ovf.
module csa_accum
    import csa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANES = 4,
    parameter int ACC_W = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef CSA_ACCUM_OVF_EN
    output logic                   out_ovf,
`endif
    output logic [ACC_W-1:0]       out_data
);

    csa_state_e       state;
    logic [ACC_W-1:0] sum_q;
    logic [ACC_W-1:0] carry_q;
    logic             seed_zero;
    logic             in_xfer;

    logic [ACC_W-1:0] row_a  [LANES];
    logic [ACC_W-1:0] row_b  [LANES];
    logic [ACC_W-1:0] row_c  [LANES];
    logic [ACC_W-1:0] row_s  [LANES];
    logic [ACC_W-1:0] row_cy [LANES];
`ifdef CSA_ACCUM_OVF_EN
    logic [LANES-1:0] row_cout;
`endif

    // A packet opened from IDLE starts from zero, so the pair never needs clearing.
    assign seed_zero = (state == IDLE);
    assign in_xfer   = in_valid && in_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_row
        logic [WIDTH-1:0] lane_op;
        assign lane_op  = in_data[lane_lsb(i, WIDTH) +: WIDTH];
        assign row_c[i] = ACC_W'(lane_op);
        if (i == 0) begin : g_seed
            assign row_a[i] = seed_zero ? '0 : sum_q;
            assign row_b[i] = seed_zero ? '0 : carry_q;
        end else begin : g_chain
            assign row_a[i] = row_s[i-1];
            assign row_b[i] = row_cy[i-1];
        end
        csa_row #(.W(ACC_W)) u_row (
            .a        (row_a[i]),
            .b        (row_b[i]),
            .c        (row_c[i]),
`ifdef CSA_ACCUM_OVF_EN
            .cout_msb (row_cout[i]),
`endif
            .s        (row_s[i]),
            .cy       (row_cy[i])
        );
    end

`ifdef CSA_ACCUM_OVF_EN
    logic [ACC_W:0] resolve_sum;
    logic           pkt_ovf_q;
    assign resolve_sum = {1'b0, sum_q} + {1'b0, carry_q};
`else
    logic [ACC_W-1:0] resolve_sum;
    assign resolve_sum = sum_q + carry_q;
`endif

    // Packet FSM: accumulate beats, resolve once, hold the result until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sum_q     <= '0;
            carry_q   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (in_xfer) begin
                        sum_q    <= row_s[LANES-1];
                        carry_q  <= row_cy[LANES-1];
                        state    <= in_last ? RESOLVE : ACC;
                        in_ready <= !in_last;
                    end
                end
                RESOLVE: begin
                    out_data  <= resolve_sum[ACC_W-1:0];
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef CSA_ACCUM_OVF_EN
    // Sticky per-packet wrap flag: any dropped compressor carry or a carry out of the final add.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_ovf_q <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            if (in_xfer) begin
                pkt_ovf_q <= (seed_zero ? 1'b0 : pkt_ovf_q) | (|row_cout);
            end
            if (state == RESOLVE) begin
                out_ovf <= pkt_ovf_q | resolve_sum[ACC_W];
            end
        end
    end
`endif

endmodule

// File: tb/tb_csa_accum.sv
// tb_csa_accum: scenario tasks with a per-packet running-total reference model for csa_accum.
// Latency: checks result timing relative to last-beat acceptance.
// Backpressure: exercises in_valid gaps, out_ready stalls and ignored input during HOLD.
module tb_csa_accum;

    localparam int WIDTH = 16;
    localparam int LANES = 4;
`ifdef CSA_ACCUM_OVF_EN
    localparam int ACC_W = 16;
`else
    localparam int ACC_W = 24;
`endif
    localparam longint unsigned MODULUS = 64'd1 << ACC_W;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in_data = '0;
    logic                   in_last = 1'b0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [ACC_W-1:0]       out_data;
`ifdef CSA_ACCUM_OVF_EN
    logic                   out_ovf;
`endif

    int checks = 0;
    int errors = 0;
    longint unsigned model_total = 0;

    always #5 clk = ~clk;

    csa_accum #(.WIDTH(WIDTH), .LANES(LANES), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef CSA_ACCUM_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .out_data  (out_data)
    );

    function automatic logic [LANES*WIDTH-1:0] mk(input int unsigned o0, input int unsigned o1,
                                                  input int unsigned o2, input int unsigned o3);
        return {16'(o3), 16'(o2), 16'(o1), 16'(o0)};
    endfunction

    function automatic logic [LANES*WIDTH-1:0] rnd_beat();
        return {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    endfunction

    function automatic logic [ACC_W-1:0] model_result();
        longint unsigned r;
        r = model_total % MODULUS;
        return r[ACC_W-1:0];
    endfunction

    // Presents one beat, waits (bounded) for acceptance, adds its operands to the model.
    task automatic send_beat(input logic [LANES*WIDTH-1:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_beat_accept in_ready=%b required 1", in_ready);
        end
        for (int i = 0; i < LANES; i++) model_total += longint'(d[i*WIDTH +: WIDTH]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = rnd_beat();
    endtask

    task automatic wait_out(output bit ok);
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (out_valid === 1'b1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_out out_valid=%b out_data=%h required 0/0", out_valid, out_data);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b required 1", in_ready);
        end
`ifdef CSA_ACCUM_OVF_EN
        checks++;
        if (out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got %b required 0", out_ovf);
        end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_ready got %b required 1", in_ready);
        end
    endtask

    task automatic test_single_latency();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = mk(1, 2, 3, 4);
        in_last   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_resolve out_valid=%b in_ready=%b required 0/0", out_valid, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== ACC_W'(10)) begin
            errors++;
            $display("FAIL single_result out_valid=%b out_data=%0d required 1/10", out_valid, out_data);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_release out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_multi_beat();
        bit ok;
        model_total = 0;
        for (int b = 0; b < 3; b++) send_beat(mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), b == 2);
        wait_out(ok);
        checks++;
        if (!ok || out_data !== model_result()) begin
            errors++;
            $display("FAIL multi_beat out_valid=%b out_data=%h required %h", out_valid, out_data, model_result());
        end
`ifdef CSA_ACCUM_OVF_EN
        checks++;
        if (out_ovf !== (model_total >= MODULUS)) begin
            errors++;
            $display("FAIL multi_beat_ovf got %b required %b", out_ovf, model_total >= MODULUS);
        end
`endif
        handshake();
    endtask

    task automatic test_gaps();
        bit ok;
        int gaps [3] = '{0, 3, 1};
        model_total = 0;
        repeat (gaps[0]) @(posedge clk);
        send_beat(mk(5, 6, 7, 8), 1'b0);
        for (int g = 0; g < gaps[1]; g++) begin
            @(posedge clk); #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL gap_in_ready cycle %0d got %b required 1", g, in_ready);
            end
        end
        send_beat(mk(5, 6, 7, 8), 1'b1);
        wait_out(ok);
        checks++;
        if (!ok || out_data !== ACC_W'(52) || out_data !== model_result()) begin
            errors++;
            $display("FAIL gaps_result out_valid=%b out_data=%0d required 52", out_valid, out_data);
        end
        repeat (gaps[2]) @(posedge clk);
        #1;
        handshake();
    endtask

    task automatic test_hold();
        bit ok;
        logic [ACC_W-1:0] exp;
        model_total = 0;
        send_beat(rnd_beat(), 1'b1);
        exp = model_result();
        wait_out(ok);
        for (int k = 0; k < 5; k++) begin
            in_valid = (k % 2 == 0);
            in_last  = 1'b1;
            in_data  = rnd_beat();
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cycle %0d out_valid=%b out_data=%h in_ready=%b required 1/%h/0",
                         k, out_valid, out_data, in_ready, exp);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        handshake();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_single_handshake out_valid=%b required 0", out_valid);
        end
        model_total = 0;
        send_beat(rnd_beat(), 1'b1);
        wait_out(ok);
        checks++;
        if (!ok || out_data !== model_result()) begin
            errors++;
            $display("FAIL hold_next_packet out_data=%h required %h", out_data, model_result());
        end
        handshake();
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        model_total = 0;
        send_beat(rnd_beat(), 1'b0);
        send_beat(rnd_beat(), 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_state out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        model_total = 0;
        send_beat(mk(1, 1, 1, 1), 1'b1);
        wait_out(ok);
        checks++;
        if (!ok || out_data !== ACC_W'(4)) begin
            errors++;
            $display("FAIL midrst_result out_valid=%b out_data=%0d required 4", out_valid, out_data);
        end
        handshake();
    endtask

    task automatic test_random_packets();
        bit ok;
        for (int p = 0; p < 12; p++) begin
            int nbeats;
            nbeats = $urandom_range(1, 4);
            model_total = 0;
            for (int b = 0; b < nbeats; b++) begin
                send_beat(rnd_beat(), b == nbeats - 1);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            wait_out(ok);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            checks++;
            if (!ok || out_valid !== 1'b1 || out_data !== model_result()) begin
                errors++;
                $display("FAIL random_pkt %0d out_valid=%b out_data=%h required %h",
                         p, out_valid, out_data, model_result());
            end
`ifdef CSA_ACCUM_OVF_EN
            checks++;
            if (out_ovf !== (model_total >= MODULUS)) begin
                errors++;
                $display("FAIL random_ovf %0d got %b required %b", p, out_ovf, model_total >= MODULUS);
            end
`endif
            handshake();
        end
    endtask

`ifdef CSA_ACCUM_OVF_EN
    task automatic test_ovf();
        bit ok;
        model_total = 0;
        send_beat(mk(16'hFFFF, 1, 0, 0), 1'b1);
        wait_out(ok);
        checks++;
        if (!ok || out_data !== model_result() || out_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set out_data=%h out_ovf=%b required %h/1", out_data, out_ovf, model_result());
        end
        handshake();
        model_total = 0;
        send_beat(mk(1, 0, 0, 0), 1'b1);
        wait_out(ok);
        checks++;
        if (!ok || out_data !== ACC_W'(1) || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear out_data=%h out_ovf=%b required 1/0", out_data, out_ovf);
        end
        handshake();
    endtask
`endif

    initial begin
        test_reset();
        test_single_latency();
        test_multi_beat();
        test_gaps();
        test_hold();
        test_reset_mid_packet();
`ifdef CSA_ACCUM_OVF_EN
        test_ovf();
`endif
        test_random_packets();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/csa_accum.md
Name: csa_accum

Overview:
- Multi-beat, multi-operand carry-save accumulator for the bitmod datapath.
- Each accepted beat carries LANES operands of WIDTH bits. All operands are folded into a redundant sum/carry pair through a tree of 3:2 compressor rows, with no carry propagation per beat.
- On the last beat of a packet, one carry-propagate add resolves the pair. The ACC_W-bit result is presented on a valid/ready output.
- Successor to the 1-bit half-adder cell: parametrised in width, lane count and accumulator width, and sequential.

Parameters:
- WIDTH, 16, bit width of each input operand (unsigned).
- LANES, 4, operands per input beat (≥1).
- ACC_W, 24, accumulator and result width (≥ WIDTH). All arithmetic is modulo 2^ACC_W.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, beat valid.
- in_ready, output, 1, block can accept a beat.
- in_data, input, LANES*WIDTH, operands; lane i occupies bits [i*WIDTH +: WIDTH].
- in_last, input, 1, final beat of the packet.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts the result.
- out_data, output, ACC_W, resolved sum of all operands in the packet, mod 2^ACC_W.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state = IDLE; sum_q = carry_q = 0; out_data = 0; out_valid = 0.
  - in_ready = 1 in the first cycle after reset is deasserted.
- Reset mid-packet or mid-output discards everything. No partial result is emitted.
- States:
  - IDLE: no packet open.
  - ACC: packet open.
  - RESOLVE: one cycle, carry-propagate add.
  - HOLD: result presented.
- Transfer rule: an input transfer occurs when in_valid && in_ready.
- in_ready = 1 in IDLE and ACC, 0 in RESOLVE and HOLD. It is a registered, state-derived signal and is never combinationally dependent on out_ready.
- Compression on each transfer:
  - Every operand is zero-extended to ACC_W.
  - The seed pair is (0,0) if state == IDLE, otherwise (sum_q, carry_q).
  - The LANES operands plus the two seed words pass through LANES rows of 3:2 compressors.
  - In each row: s = a^b^c; cy = ((a&b)|(a&c)|(b&c)) << 1, truncated to ACC_W (MSB carry discarded).
  - The final pair is registered into sum_q/carry_q in the same edge.
- Transitions on a transfer:
  - in_last = 0: go to ACC.
  - in_last = 1: go to RESOLVE.
  - A single-beat packet (in_last on the first beat) goes IDLE → RESOLVE directly.
- RESOLVE: out_data <= sum_q + carry_q (ACC_W bits, overflow wraps); out_valid <= 1; next state HOLD.
- HOLD: out_valid and out_data are stable until out_ready.
  - When out_valid && out_ready: out_valid <= 0, state <= IDLE.
  - sum_q/carry_q are not cleared; IDLE seeding makes clearing unnecessary.
- Latency:
  - Last beat accepted at edge t; out_valid high after edge t+1.
  - Earliest next input acceptance is the cycle after the output handshake.
  - Throughput is 1 beat/cycle within a packet, plus 2 bubble cycles per packet.
- in_valid while in_ready = 0 is held by the upstream; in_data is ignored.
- Bubbles inside a packet are allowed. ACC holds sum_q/carry_q indefinitely while in_valid = 0.

Optional Feature:
- Macro: CSA_ACCUM_OVF_EN.
- Defined:
  - Adds output port out_ovf (1 bit), reset 0, valid with out_valid.
  - out_ovf is set if any 3:2 row discarded a 1 at bit ACC_W in the packet, or if the final add carried out of ACC_W.
  - Sticky per packet. Cleared on entering a new packet from IDLE.
- Not defined: the port and its tracking logic are absent. Wrap-around is silent.

Decomposition:
- Package csa_pkg:
  - State enum csa_state_e {IDLE, ACC, RESOLVE, HOLD}.
  - Localparam-style helper function for lane slicing.
  - No width constants; widths stay as module parameters.
- Sub-module csa_row: parametrised by W. Inputs a, b, c [W]; outputs s, cy [W], with cy already shifted and truncated. Under CSA_ACCUM_OVF_EN it also has a 1-bit cout_msb.
- csa_accum instantiates LANES csa_row copies in a generate loop.

Test Plan:
- Reset, then one beat with lanes {1,2,3,4} and in_last = 1, out_ready = 1 → out_valid exactly 2 cycles after acceptance, out_data = 10, then in_ready returns high.
- Three beats of {0xFFFF ×4}, last on beat 3, WIDTH = 16, ACC_W = 24 → out_data = 12*0xFFFF = 0x0BFFF4.
- Beats with in_valid gaps of 0/3/1 cycles, operands {5,6,7,8} twice → out_data = 52; in_ready stays 1 during gaps.
- Hold out_ready = 0 for 5 cycles → out_valid and out_data stable, in_ready = 0, and in_valid pulses are ignored; release → single handshake, next packet sums from 0.
- Assert rst mid-packet after 2 beats, then send a fresh single beat {1,1,1,1} → out_data = 4, no stale output.
- With CSA_ACCUM_OVF_EN, ACC_W = 16: beat {0xFFFF,1,0,0} → out_data = 0x0000, out_ovf = 1; next packet {1,0,0,0} → out_ovf = 0.
